// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM (FETCH/DECODE/EXEC/MEM/WB) with registered outputs.
// Optional retired-instruction counter compiled in by defining CTRL_RETIRE_CNT_EN.
module multi_cycle_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  OPCode,
   input  logic [5:0]  Funct,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic [1:0]  RegDst,
   output logic        ALUSrc,
   output logic        RegWrite,
   output logic        MemWrite,
   output logic [1:0]  MemToReg,
   output logic        ExtOp,
   output logic [1:0]  nPC_sel,
   output logic [2:0]  ALUCtrl,
   output logic        retire,
   output logic [31:0] instr_cnt,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4
   } state_t;

   typedef enum logic [3:0] {
      C_NOP = 4'd0, C_ADDU = 4'd1, C_SUBU = 4'd2, C_ORI = 4'd3, C_LW = 4'd4,
      C_SW = 4'd5, C_BEQ = 4'd6, C_LUI = 4'd7, C_JAL = 4'd8, C_JR = 4'd9
   } cls_t;

   function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
      cls_t c;
      case (op)
         6'b000000: begin
            case (fn)
               6'b100001: c = C_ADDU;
               6'b100011: c = C_SUBU;
               6'b001000: c = C_JR;
               default:   c = C_NOP;
            endcase
         end
         6'b001101: c = C_ORI;
         6'b100011: c = C_LW;
         6'b101011: c = C_SW;
         6'b000100: c = C_BEQ;
         6'b001111: c = C_LUI;
         6'b000011: c = C_JAL;
         default:   c = C_NOP;
      endcase
      return c;
   endfunction

   function automatic state_t final_state(input cls_t c);
      state_t s;
      case (c)
         C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW: s = S_WB;
         C_SW:                               s = S_MEM;
         C_BEQ, C_JAL, C_JR:                 s = S_EXEC;
         default:                            s = S_DECODE;
      endcase
      return s;
   endfunction

   state_t      state_q, state_d;
   logic        hold_q, hold_d;
   logic [5:0]  op_q, op_d, fn_q, fn_d;
   cls_t        cls_q, cls_d;

   logic        irwrite_d, pcwrite_d, regwrite_d, memwrite_d, alusrc_d, extop_d;
   logic [1:0]  regdst_d, memtoreg_d, npc_sel_d;
   logic [2:0]  aluctrl_d;

   assign cls_q = classify(op_q, fn_q);
   assign cls_d = classify(op_d, fn_d);

   // Next state; hold_q keeps FETCH for one cycle after reset so IRWrite is seen right after release
   always_comb begin
      state_d = state_q;
      hold_d  = 1'b0;
      op_d    = op_q;
      fn_d    = fn_q;
      if (hold_q) begin
         state_d = S_FETCH;
      end else begin
         case (state_q)
            S_FETCH: begin
               state_d = S_DECODE;
               op_d    = OPCode;
               fn_d    = Funct;
            end
            S_DECODE: state_d = (cls_q == C_NOP) ? S_FETCH : S_EXEC;
            S_EXEC: begin
               if (final_state(cls_q) == S_EXEC) begin
                  state_d = S_FETCH;
               end else begin
                  state_d = (cls_q == C_LW || cls_q == C_SW) ? S_MEM : S_WB;
               end
            end
            S_MEM:   state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
            S_WB:    state_d = S_FETCH;
            default: state_d = S_FETCH;
         endcase
      end
   end

   // Output values for the state being entered, so the output flops line up with state_q
   always_comb begin
      irwrite_d  = (state_d == S_FETCH);
      pcwrite_d  = (state_d == final_state(cls_d));
      regwrite_d = (state_d == S_WB) || (state_d == S_EXEC && cls_d == C_JAL);
      memwrite_d = (state_d == S_MEM) && (cls_d == C_SW);
      regdst_d   = 2'b00;
      alusrc_d   = 1'b0;
      memtoreg_d = 2'b00;
      extop_d    = 1'b0;
      npc_sel_d  = 2'b00;
      aluctrl_d  = 3'b000;
      if (state_d == S_EXEC || state_d == S_MEM || state_d == S_WB) begin
         case (cls_d)
            C_ADDU: regdst_d = 2'b01;
            C_SUBU: begin regdst_d = 2'b01; aluctrl_d = 3'b001; end
            C_ORI:  begin alusrc_d = 1'b1; aluctrl_d = 3'b010; end
            C_LW:   begin alusrc_d = 1'b1; memtoreg_d = 2'b01; extop_d = 1'b1; end
            C_SW:   begin alusrc_d = 1'b1; extop_d = 1'b1; end
            C_BEQ:  begin extop_d = 1'b1; aluctrl_d = 3'b001; npc_sel_d = 2'b01; end
            C_LUI:  begin alusrc_d = 1'b1; memtoreg_d = 2'b10; end
            C_JAL:  begin regdst_d = 2'b10; memtoreg_d = 2'b11; npc_sel_d = 2'b10; end
            C_JR:   npc_sel_d = 2'b11;
            default: regdst_d = 2'b00;
         endcase
      end else begin
         aluctrl_d = 3'b000;
      end
   end

   // State, latched instruction fields and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_FETCH;
         hold_q   <= 1'b1;
         op_q     <= 6'd0;
         fn_q     <= 6'd0;
         IRWrite  <= 1'b0;
         PCWrite  <= 1'b0;
         RegWrite <= 1'b0;
         MemWrite <= 1'b0;
         retire   <= 1'b0;
         RegDst   <= 2'b00;
         ALUSrc   <= 1'b0;
         MemToReg <= 2'b00;
         ExtOp    <= 1'b0;
         nPC_sel  <= 2'b00;
         ALUCtrl  <= 3'b000;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         op_q     <= op_d;
         fn_q     <= fn_d;
         IRWrite  <= irwrite_d;
         PCWrite  <= pcwrite_d;
         RegWrite <= regwrite_d;
         MemWrite <= memwrite_d;
         retire   <= pcwrite_d;
         RegDst   <= regdst_d;
         ALUSrc   <= alusrc_d;
         MemToReg <= memtoreg_d;
         ExtOp    <= extop_d;
         nPC_sel  <= npc_sel_d;
         ALUCtrl  <= aluctrl_d;
      end
   end

   assign state = state_q;

`ifdef CTRL_RETIRE_CNT_EN
   logic [31:0] cnt_q;

   // Retired-instruction counter, wraps naturally at 32 bits
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= 32'd0;
      end else if (retire) begin
         cnt_q <= cnt_q + 32'd1;
      end else begin
         cnt_q <= cnt_q;
      end
   end

   assign instr_cnt = cnt_q;
`else
   assign instr_cnt = 32'd0;
`endif

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset (0 sampled at clk rising edge = reset).
REQ-003 SHALL have port: OPCode  input  6  instruction bits [31:26] from datapath.
REQ-004 SHALL have port: Funct  input  6  instruction bits [5:0] from datapath.
REQ-005 SHALL have port: IRWrite  output  1  datapath latches the instruction this cycle.
REQ-006 SHALL have port: PCWrite  output  1  datapath loads next PC this cycle.
REQ-007 SHALL have ports: RegDst[1:0], ALUSrc, RegWrite, MemWrite, MemToReg[1:0], ExtOp, nPC_sel[1:0], ALUCtrl[2:0] as outputs, with the datapath's encodings:
- RegDst 00 rt / 01 rd / 10 $31.
- MemToReg 00 ALU / 01 mem / 10 lui / 11 PC+4.
- nPC_sel 00 PC+4 / 01 beq / 10 jal / 11 jr.
- ALUCtrl 000 add / 001 sub / 010 or.
- ExtOp 1 sign / 0 zero.
REQ-008 SHALL have port: retire  output  1  one-cycle pulse in the final state of each instruction.
REQ-009 SHALL have port: instr_cnt  output  32  retired-instruction count (see Configuration).
REQ-010 SHALL have port: state  output  3  current FSM state, for debug.

Function
REQ-011 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-012 SHALL register OPCode/Funct on the FETCH->DECODE edge; all later decoding SHALL use the registered copy.
REQ-013 SHALL always go FETCH->DECODE; FETCH SHALL assert IRWrite=1 and hold all other enables at 0.
REQ-014 SHALL decode addu(000000/100001), subu(000000/100011), ori(001101), lw(100011), sw(101011), beq(000100), lui(001111), jal(000011) and jr(000000/001000).
REQ-015 SHALL treat any other encoding, including all-zero nop, as a no-op: PCWrite=1, nPC_sel=00 and retire=1 in DECODE, then return to FETCH (2 cycles).
REQ-016 SHALL use these state sequences:
- addu/subu/ori/lui: FETCH,DECODE,EXEC,WB (4 cycles).
- lw: FETCH,DECODE,EXEC,MEM,WB (5 cycles).
- sw: FETCH,DECODE,EXEC,MEM (4 cycles).
- beq/jal/jr: FETCH,DECODE,EXEC (3 cycles).
REQ-017 SHALL assert RegWrite only in WB, or in EXEC for jal (RegDst=10, MemToReg=11), and never in any other state.
REQ-018 SHALL assert MemWrite only in MEM for sw.
REQ-019 SHALL assert PCWrite and retire in exactly one cycle per instruction: the final state.
- nPC_sel SHALL be 01 for beq, 10 for jal, 11 for jr, and 00 otherwise.
- The datapath resolves the beq Zero condition.
REQ-020 SHALL hold ALUSrc, ALUCtrl, ExtOp, RegDst and MemToReg stable from EXEC through the instruction's final state.
- ori: ExtOp=0.
- lw/sw/beq: ExtOp=1.
- subu and beq: ALUCtrl=001.
REQ-021 SHALL drive all outputs as functions of registered state and opcode only, with no combinational path from inputs to outputs.

Reset
REQ-022 SHALL, when reset=0 at a rising edge, enter FETCH, clear the registered opcode/funct to 0 and clear instr_cnt to 0.
REQ-023 SHALL force IRWrite, PCWrite, RegWrite, MemWrite and retire to 0 whenever reset=0, including reset mid-instruction (e.g. in MEM of sw: no write).
REQ-024 SHALL resume with FETCH in the first cycle after reset returns to 1.

Configuration
REQ-025 SHALL compile the retire counter only when CTRL_RETIRE_CNT_EN is defined.
- Defined: instr_cnt increments by 1 on each retire, wraps 0xFFFFFFFF->0.
- Undefined: instr_cnt is constant 0 and no counter flops are synthesized.

Verification
REQ-026 SHALL verify reset: hold reset=0 for 3 cycles mid-lw -> state=0 and all enables 0; first cycle after release -> IRWrite=1.
REQ-027 SHALL verify lw (OPCode=100011): state sequence 0,1,2,3,4; RegWrite=1 with MemToReg=01 and RegDst=00 only at state 4; PCWrite=1 only at state 4.
REQ-028 SHALL verify sw then beq: MemWrite=1 exactly once, at state 3 of sw; beq shows nPC_sel=01 with PCWrite=1 at state 2 and RegWrite never 1.
REQ-029 SHALL verify jal (000011): 3-cycle instruction; state 2 has RegWrite=1, RegDst=10, MemToReg=11, nPC_sel=10, PCWrite=1.
REQ-030 SHALL verify nop/unknown (OPCode=111111): retires in 2 cycles with nPC_sel=00 and no RegWrite/MemWrite.
REQ-031 SHALL verify the counter with CTRL_RETIRE_CNT_EN: 10 mixed instructions -> instr_cnt=10; preload-free run to a forced 0xFFFFFFFF -> next retire gives 0; without the macro -> instr_cnt=0 throughout.
